// File: rtl/register_file_wb.sv
// 32 x 32-bit MIPS register file: two async read ports, one debug read port,
// one synchronous write port and a saturating committed-write counter.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data to all read ports.
module register_file_wb #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 5,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   RegWrite,
  input  logic [ADDR_WIDTH-1:0]  WriteRegister,
  input  logic [DATA_WIDTH-1:0]  WriteData,
  input  logic [ADDR_WIDTH-1:0]  ReadRegister1,
  input  logic [ADDR_WIDTH-1:0]  ReadRegister2,
  output logic [DATA_WIDTH-1:0]  ReadData1,
  output logic [DATA_WIDTH-1:0]  ReadData2,
  input  logic [ADDR_WIDTH-1:0]  DebugRegister,
  output logic [DATA_WIDTH-1:0]  DebugData,
  output logic [COUNT_WIDTH-1:0] WriteCount
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  // Register 0 is hardwired to zero, so storage starts at index 1.
  logic [DATA_WIDTH-1:0]  regs_q [1:DEPTH-1];
  logic [COUNT_WIDTH-1:0] count_q;
  logic [COUNT_WIDTH-1:0] count_d;
  logic                   wr_commit;

  logic [ADDR_WIDTH-1:0]  rd_addr [3];
  logic [DATA_WIDTH-1:0]  rd_data [3];

  assign wr_commit = RegWrite && (WriteRegister != '0);

  always_comb begin
    count_d = count_q;
    if (wr_commit && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int unsigned i = 1; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      count_q <= '0;
    end else begin
      if (wr_commit) begin
        regs_q[WriteRegister] <= WriteData;
      end
      count_q <= count_d;
    end
  end

  always_comb begin
    rd_addr[0] = ReadRegister1;
    rd_addr[1] = ReadRegister2;
    rd_addr[2] = DebugRegister;
    for (int unsigned p = 0; p < 3; p++) begin
      rd_data[p] = '0;
      if (rd_addr[p] != '0) begin
`ifdef REGFILE_BYPASS_EN
        // Reset has priority over the write, so no forwarding while it is asserted.
        if (wr_commit && !Reset && (rd_addr[p] == WriteRegister)) begin
          rd_data[p] = WriteData;
        end else begin
          rd_data[p] = regs_q[rd_addr[p]];
        end
`else
        rd_data[p] = regs_q[rd_addr[p]];
`endif
      end
    end
  end

  assign ReadData1  = rd_data[0];
  assign ReadData2  = rd_data[1];
  assign DebugData  = rd_data[2];
  assign WriteCount = count_q;

endmodule

// File: tb/tb_register_file_wb.sv
// Directed self-checking bench for register_file_wb, default and bypass builds,
// plus a 4-bit-counter instance for saturation.
module tb_register_file_wb;

  logic        Clk;
  logic        Reset;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic [4:0]  ReadRegister1;
  logic [4:0]  ReadRegister2;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
  logic [4:0]  DebugRegister;
  logic [31:0] DebugData;
  logic [15:0] WriteCount;

  logic        s_reset;
  logic        s_regwrite;
  logic [4:0]  s_wreg;
  logic [31:0] s_wdata;
  logic [4:0]  s_rreg1;
  logic [4:0]  s_rreg2;
  logic [31:0] s_rdata1;
  logic [31:0] s_rdata2;
  logic [4:0]  s_dreg;
  logic [31:0] s_ddata;
  logic [3:0]  s_count;

  int checks = 0;
  int errors = 0;

  register_file_wb dut (
    .Clk(Clk), .Reset(Reset), .RegWrite(RegWrite),
    .WriteRegister(WriteRegister), .WriteData(WriteData),
    .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .ReadData1(ReadData1), .ReadData2(ReadData2),
    .DebugRegister(DebugRegister), .DebugData(DebugData),
    .WriteCount(WriteCount)
  );

  register_file_wb #(.COUNT_WIDTH(4)) dut_sat (
    .Clk(Clk), .Reset(s_reset), .RegWrite(s_regwrite),
    .WriteRegister(s_wreg), .WriteData(s_wdata),
    .ReadRegister1(s_rreg1), .ReadRegister2(s_rreg2),
    .ReadData1(s_rdata1), .ReadData2(s_rdata2),
    .DebugRegister(s_dreg), .DebugData(s_ddata),
    .WriteCount(s_count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_reads(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad);
    ReadRegister1 = a1;
    ReadRegister2 = a2;
    DebugRegister = ad;
    #1;
  endtask

  task automatic write_reg(input logic [4:0] addr, input logic [31:0] data);
    RegWrite      = 1'b1;
    WriteRegister = addr;
    WriteData     = data;
    tick();
    RegWrite      = 1'b0;
  endtask

  logic [4:0]  vec_addr [4];
  logic [31:0] vec_data [4];
  logic [31:0] same_cycle_exp;
  int          exp_cnt;

  initial begin
    Reset = 1'b1; RegWrite = 1'b0; WriteRegister = '0; WriteData = '0;
    ReadRegister1 = '0; ReadRegister2 = '0; DebugRegister = '0;
    s_reset = 1'b1; s_regwrite = 1'b0; s_wreg = '0; s_wdata = '0;
    s_rreg1 = 5'd1; s_rreg2 = '0; s_dreg = 5'd1;
    tick();
    Reset = 1'b0;
    s_reset = 1'b0;

    set_reads(5'd5, 5'd8, 5'd31);
    check("rst_rd1", ReadData1, 32'h0);
    check("rst_rd2", ReadData2, 32'h0);
    check("rst_dbg", DebugData, 32'h0);
    check("rst_cnt", {16'h0, WriteCount}, 32'd0);

    // Preload then reset clears
    write_reg(5'd5, 32'hDEADBEEF);
    set_reads(5'd5, 5'd0, 5'd5);
    check("preload_rd1", ReadData1, 32'hDEADBEEF);
    check("preload_cnt", {16'h0, WriteCount}, 32'd1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    #1;
    check("reset_clr_rd1", ReadData1, 32'h0);
    check("reset_clr_dbg", DebugData, 32'h0);
    check("reset_clr_cnt", {16'h0, WriteCount}, 32'd0);

    // Basic write/read on all three ports
    write_reg(5'd8, 32'h12345678);
    set_reads(5'd8, 5'd8, 5'd8);
    check("basic_rd1", ReadData1, 32'h12345678);
    check("basic_rd2", ReadData2, 32'h12345678);
    check("basic_dbg", DebugData, 32'h12345678);
    check("basic_cnt", {16'h0, WriteCount}, 32'd1);

    // Register 0 is immutable and its writes are not counted
    write_reg(5'd0, 32'hFFFFFFFF);
    set_reads(5'd0, 5'd8, 5'd0);
    check("r0_rd1", ReadData1, 32'h0);
    check("r0_dbg", DebugData, 32'h0);
    check("r0_cnt", {16'h0, WriteCount}, 32'd1);

    // JAL writes r31; same-cycle read depends on forwarding
`ifdef REGFILE_BYPASS_EN
    same_cycle_exp = 32'h00400010;
`else
    same_cycle_exp = 32'h00000000;
`endif
    RegWrite = 1'b1; WriteRegister = 5'd31; WriteData = 32'h00400010;
    set_reads(5'd0, 5'd31, 5'd31);
    check("jal_same_rd2", ReadData2, same_cycle_exp);
    check("jal_same_dbg", DebugData, same_cycle_exp);
    check("jal_same_rd1_r0", ReadData1, 32'h0);
    tick();
    RegWrite = 1'b0;
    #1;
    check("jal_next_rd2", ReadData2, 32'h00400010);
    check("jal_cnt", {16'h0, WriteCount}, 32'd2);

    // RegWrite=0 leaves state untouched
    WriteRegister = 5'd8; WriteData = 32'hCAFEF00D;
    tick();
    set_reads(5'd8, 5'd31, 5'd8);
    check("nowr_rd1", ReadData1, 32'h12345678);
    check("nowr_cnt", {16'h0, WriteCount}, 32'd2);

    // Several distinct registers, read back in mixed combinations
    vec_addr[0] = 5'd2;  vec_data[0] = 32'hA5A5A5A5;
    vec_addr[1] = 5'd7;  vec_data[1] = 32'h0000_0001;
    vec_addr[2] = 5'd16; vec_data[2] = 32'h8000_0000;
    vec_addr[3] = 5'd30; vec_data[3] = 32'h5A5A_C3C3;
    for (int i = 0; i < 4; i++) write_reg(vec_addr[i], vec_data[i]);
    for (int i = 0; i < 4; i++) begin
      set_reads(vec_addr[i], vec_addr[3-i], vec_addr[(i+1)%4]);
      check("vec_rd1", ReadData1, vec_data[i]);
      check("vec_rd2", ReadData2, vec_data[3-i]);
      check("vec_dbg", DebugData, vec_data[(i+1)%4]);
    end
    check("vec_cnt", {16'h0, WriteCount}, 32'd6);
    set_reads(5'd8, 5'd31, 5'd5);
    check("mix_rd1", ReadData1, 32'h12345678);
    check("mix_rd2", ReadData2, 32'h00400010);
    check("mix_dbg", DebugData, 32'h0);

    // Reset beats a same-edge write
    Reset = 1'b1; RegWrite = 1'b1; WriteRegister = 5'd3; WriteData = 32'hAAAA5555;
    tick();
    Reset = 1'b0; RegWrite = 1'b0;
    set_reads(5'd3, 5'd8, 5'd31);
    check("coll_rd1", ReadData1, 32'h0);
    check("coll_rd2", ReadData2, 32'h0);
    check("coll_dbg", DebugData, 32'h0);
    check("coll_cnt", {16'h0, WriteCount}, 32'd0);

    // Saturating 4-bit counter on the second instance
    for (int i = 0; i < 20; i++) begin
      s_regwrite = 1'b1; s_wreg = 5'd1; s_wdata = 32'h100 + i;
      tick();
      s_regwrite = 1'b0;
      #1;
      exp_cnt = (i + 1 > 15) ? 15 : i + 1;
      check("sat_cnt", {28'h0, s_count}, exp_cnt);
    end
    check("sat_rd1", s_rdata1, 32'h113);
    check("sat_dbg", s_ddata, 32'h113);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_file_wb.md
Name: register_file_wb

Overview:
- 32 x 32-bit MIPS general-purpose register file.
- Sits directly downstream of the 5-bit 3:1 write-register-select mux. That mux's output drives WriteRegister here; its legal encodings are rt, rd and 31 for JAL.
- Provides two asynchronous read ports for the decode stage and one synchronous write port for writeback.
- Also provides a debug read port and a committed-write counter for bench and board visibility.

Parameters:
DATA_WIDTH, 32, width of each register and of all data ports
ADDR_WIDTH, 5, register address width; depth = 2**ADDR_WIDTH
COUNT_WIDTH, 16, width of the committed-write counter

Ports:
Clk  input  1  system clock; all state updates on rising edge
Reset  input  1  synchronous, active-high reset
RegWrite  input  1  write enable from control
WriteRegister  input  ADDR_WIDTH  destination register, from write-register-select mux
WriteData  input  DATA_WIDTH  writeback value (ALU result or memory data)
ReadRegister1  input  ADDR_WIDTH  rs address
ReadRegister2  input  ADDR_WIDTH  rt address
ReadData1  output  DATA_WIDTH  contents of ReadRegister1
ReadData2  output  DATA_WIDTH  contents of ReadRegister2
DebugRegister  input  ADDR_WIDTH  debug read address
DebugData  output  DATA_WIDTH  contents of DebugRegister
WriteCount  output  COUNT_WIDTH  number of committed writes since reset

Behaviour:
- One clock; reset is synchronous and active-high. Reset is sampled only on the rising edge of Clk.
- Reset asserted at a rising edge:
  - All 32 registers load 0.
  - WriteCount loads 0.
  - Any same-edge write is discarded; reset has priority over RegWrite.
- Reset mid-operation: state is cleared on the first rising edge with Reset=1. Read outputs reflect 0 combinationally after that edge.
- Write, at rising edge with Reset=0 and RegWrite=1:
  - WriteRegister != 0: reg[WriteRegister] <= WriteData.
  - WriteRegister == 0: no register change; register 0 is hardwired to 0 and is never stored.
- Write latency is 1 cycle: new value visible on read ports after the edge.
- WriteCount increments by 1 on each committed write, i.e. RegWrite=1, WriteRegister != 0, Reset=0.
- WriteCount saturates at all-ones; it does not wrap.
- Writes to register 0 do not count.
- Reads (ReadData1, ReadData2, DebugData) are purely combinational from current register state and address.
- Any read of address 0 returns 0.
- All three read ports are independent; any address combination is legal, including all three equal.
- Read of the address being written in the same cycle returns the OLD value, unless REGFILE_BYPASS_EN is defined (see below).
- RegWrite=0: no state change; WriteRegister/WriteData are don't-care.
- No X propagation: all registers have a defined reset value; outputs after first reset are never X.
- Output reset values: ReadData1 = ReadData2 = DebugData = 0 and WriteCount = 0 after a reset edge.

Optional Feature:
- Macro: REGFILE_BYPASS_EN
- Defined: internal write-to-read forwarding.
  - Applies when RegWrite=1, Reset=0, WriteRegister != 0 and a read address equals WriteRegister.
  - That read port returns WriteData in the same cycle, combinationally.
  - Applies to ReadData1, ReadData2 and DebugData.
  - Address 0 is never bypassed and still reads 0.
- Not defined: no forwarding. Same-cycle read returns the pre-edge stored value; new value appears the cycle after the write.
- WriteCount behaviour is identical in both builds.

Test Plan:
- Reset clears: preload reg 5 = 0xDEADBEEF, assert Reset one edge -> ReadRegister1=5 gives 0x00000000, WriteCount=0.
- Basic write/read: RegWrite=1, WriteRegister=8, WriteData=0x12345678, one edge, RegWrite=0; ReadRegister1=8, ReadRegister2=8, DebugRegister=8 -> all read 0x12345678, WriteCount=1.
- Register 0 immutability: RegWrite=1, WriteRegister=0, WriteData=0xFFFFFFFF, one edge -> ReadData1 for addr 0 = 0, WriteCount unchanged.
- JAL path: write WriteRegister=31 with 0x00400010 -> ReadRegister2=31 gives 0x00400010 next cycle. Same-cycle read:
  - Bypass build: 0x00400010.
  - Non-bypass build: prior value 0.
- Reset vs write collision: Reset=1 and RegWrite=1, WriteRegister=3, WriteData=0xAAAA5555 on same edge -> reg 3 = 0, WriteCount = 0.
- Counter saturation: COUNT_WIDTH=4, perform 20 writes to register 1 -> WriteCount reaches 15 and holds at 15. Reg 1 holds the last written value.
